// File: rtl/reg_bank_pkg.sv
// Shared address map and constants for the reg_bank control/status register block.
package reg_bank_pkg;

  localparam logic [7:0] ADDR_ID        = 8'h00;
  localparam logic [7:0] ADDR_VERSION   = 8'h01;
  localparam logic [7:0] ADDR_SCRATCH   = 8'h02;
  localparam logic [7:0] ADDR_STATUS    = 8'h03;
  localparam logic [7:0] ADDR_IRQ_EN    = 8'h04;
  localparam logic [7:0] ADDR_CTRL      = 8'h05;
  localparam logic [7:0] ADDR_ERR_CNT   = 8'h06;
  localparam logic [7:0] ADDR_CFG_BASE  = 8'h10;
  localparam logic [7:0] ADDR_STAT_BASE = 8'h20;

  localparam int         STAT_BYTES  = 8;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/reg_bank_edge_det.sv
// 8-bit registered rising-edge detector; rise is high for one cycle after each 0->1 on d.
module reg_bank_edge_det (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d,
  output logic [7:0] rise
);

  logic [7:0] prev;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '0;
      rise <= '0;
    end else begin
      prev <= d;
      rise <= d & ~prev;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Byte-wide control/status register bank behind the UART register-access interface.
// Optional error counter at 0x06 is built only when REG_BANK_ERR_CNT_EN is defined.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int         NUM_CFG  = 8,
  parameter logic [7:0] ID_VALUE = 8'hA5,
  parameter logic [7:0] VERSION  = 8'h01
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           address,
  input  logic [7:0]           data_write_to_reg,
  input  logic                 reg_en,
  input  logic                 write_en,
  output logic [7:0]           data_read_from_reg,
  input  logic [7:0]           event_in,
  input  logic [63:0]          stat_in,
  output logic [8*NUM_CFG-1:0] cfg_out,
  output logic [7:0]           ctrl_pulse,
  output logic                 irq
);

  logic       wr, rd;
  logic [7:0] rise;
  logic [7:0] scratch, status, irq_en;
  logic [7:0] cfg_q [NUM_CFG];
  logic [7:0] rd_val;
  logic [7:0] status_clr;

  assign wr = reg_en & write_en;
  assign rd = reg_en & ~write_en;
  assign status_clr = (wr && address == ADDR_STATUS) ? data_write_to_reg : 8'h00;

  reg_bank_edge_det u_edge_det (
    .clk   (clk),
    .reset (reset),
    .d     (event_in),
    .rise  (rise)
  );

`ifdef REG_BANK_ERR_CNT_EN
  logic [7:0] err_cnt;
  logic       is_cfg, is_stat, mapped;

  always_comb begin
    is_cfg  = (address >= ADDR_CFG_BASE) && (address < ADDR_CFG_BASE + 8'(NUM_CFG));
    is_stat = (address >= ADDR_STAT_BASE) && (address < ADDR_STAT_BASE + 8'(STAT_BYTES));
    mapped  = is_cfg || is_stat || (address <= ADDR_ERR_CNT);
  end

  // A clear by write to the counter itself takes priority over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (wr && address == ADDR_ERR_CNT) begin
      err_cnt <= '0;
    end else if (reg_en && !mapped && err_cnt != ERR_CNT_MAX) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    rd_val = 8'h00;
    case (address)
      ADDR_ID:      rd_val = ID_VALUE;
      ADDR_VERSION: rd_val = VERSION;
      ADDR_SCRATCH: rd_val = scratch;
      ADDR_STATUS:  rd_val = status;
      ADDR_IRQ_EN:  rd_val = irq_en;
`ifdef REG_BANK_ERR_CNT_EN
      ADDR_ERR_CNT: rd_val = err_cnt;
`endif
      default:      rd_val = 8'h00;
    endcase
    for (int k = 0; k < NUM_CFG; k++)
      if (address == ADDR_CFG_BASE + 8'(k)) rd_val = cfg_q[k];
    for (int n = 0; n < STAT_BYTES; n++)
      if (address == ADDR_STAT_BASE + 8'(n)) rd_val = stat_in[8*n +: 8];
  end

  // NOTE: the config array is small and its values are visible on cfg_out, so it is reset like any other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_read_from_reg <= '0;
      scratch            <= '0;
      status             <= '0;
      irq_en             <= '0;
      ctrl_pulse         <= '0;
      irq                <= 1'b0;
      for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= '0;
    end else begin
      if (rd) data_read_from_reg <= rd_val;
      if (wr && address == ADDR_SCRATCH) scratch <= data_write_to_reg;
      if (wr && address == ADDR_IRQ_EN)  irq_en  <= data_write_to_reg;
      ctrl_pulse <= (wr && address == ADDR_CTRL) ? data_write_to_reg : 8'h00;
      // Set is OR-ed in after the clear so a coincident edge wins.
      status <= (status & ~status_clr) | rise;
      irq    <= |(status & irq_en);
      for (int k = 0; k < NUM_CFG; k++)
        if (wr && address == ADDR_CFG_BASE + 8'(k)) cfg_q[k] <= data_write_to_reg;
    end
  end

  for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg_out
    assign cfg_out[8*k +: 8] = cfg_q[k];
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Byte-wide control/status register bank sitting directly downstream of the UART register-access interface. It consumes the address, write-data, reg_en and write_en strobes and returns read data. It holds ID/version constants, a scratch register, sticky event flags with interrupt masking, self-clearing command pulses, a bank of exported configuration registers and read-only status inputs. One access per cycle; no back-pressure.

## Interface
- NUM_CFG, 8: number of exported RW config registers, legal 1..16.
- ID_VALUE, 8'hA5: constant returned at address 0x00.
- VERSION, 8'h01: constant returned at address 0x01.
- clk  in  1  single clock; everything is synchronous to its rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  8  register address, qualified by reg_en.
- data_write_to_reg  in  8  write data, qualified by reg_en & write_en.
- reg_en  in  1  access strobe, one cycle per access.
- write_en  in  1  1 = write, 0 = read; only meaningful with reg_en.
- data_read_from_reg  out  8  registered read data.
- event_in  in  8  event sources, rising edge sets the STATUS bit.
- stat_in  in  64  read-only status, 8 bytes.
- cfg_out  out  8*NUM_CFG  config registers; byte k = register 0x10+k.
- ctrl_pulse  out  8  one-cycle command pulses.
- irq  out  1  level interrupt.

## Operation
- Address map:
  - 0x00 ID (RO).
  - 0x01 VERSION (RO).
  - 0x02 SCRATCH (RW).
  - 0x03 STATUS (sticky, W1C).
  - 0x04 IRQ_EN (RW).
  - 0x05 CTRL (WO pulse, reads 0x00).
  - 0x06 ERR_CNT.
  - 0x10..0x10+NUM_CFG-1 CFG (RW).
  - 0x20..0x27 STAT: byte n = stat_in[8n+7:8n], RO.
  - Everything else is unmapped.
- Read access (reg_en=1, write_en=0): data_read_from_reg is loaded with the addressed value. Unmapped and CTRL return 0x00. The value holds until the next read access; writes do not disturb it.
- Write access: RW registers load the data. Writes to RO addresses are ignored.
- STATUS: each bit is set when its event_in bit shows a rising edge (edge detector registered, edge seen when event_in=1 and its previous sample=0). A write clears the bits where the data is 1. If a set and a clear hit the same bit in the same cycle, set wins.
- CTRL write: ctrl_pulse = data for exactly the next cycle, then 0. Back-to-back writes give back-to-back pulses.
- irq = |(STATUS & IRQ_EN), registered.
- ERR_CNT: increments on any read or write to an unmapped address and saturates at 0xFF. A write to 0x06 clears it to 0. Reads return the count.

## Timing
- Read latency: data is valid at the first rising edge after the reg_en cycle. The upstream samples it one or two cycles later; both are correct.
- Write takes effect at the edge ending the reg_en cycle. A read of the same register on the next access returns the new value.
- Event edge to STATUS bit: 2 cycles (edge-detector flop, then STATUS flop). STATUS to irq: 1 more cycle.
- Reset values:
  - data_read_from_reg 0x00, cfg_out all 0, ctrl_pulse 0, irq 0.
  - STATUS, IRQ_EN, SCRATCH, ERR_CNT 0.
  - The edge-detector history resets to 0, so an event_in held high through reset sets STATUS on the first cycle after release.
- Reset asserted mid-pulse forces ctrl_pulse to 0 immediately (asynchronous).

## Configuration
- REG_BANK_ERR_CNT_EN defined: ERR_CNT is implemented as above.
- Not defined: no counter logic. 0x06 behaves as unmapped (reads 0x00, writes ignored); nothing is counted.

## Structure
- Package reg_bank_pkg holds:
  - address localparams ADDR_ID, ADDR_VERSION, ADDR_SCRATCH, ADDR_STATUS, ADDR_IRQ_EN, ADDR_CTRL, ADDR_ERR_CNT, ADDR_CFG_BASE, ADDR_STAT_BASE;
  - STAT_BYTES = 8;
  - ERR_CNT_MAX = 8'hFF.
- One sub-module, reg_bank_edge_det: 8-bit registered rising-edge detector with asynchronous active-high reset, instantiated on event_in.

## Test plan
- Reset, then read 0x00, 0x01, 0x02 -> 0xA5, 0x01, 0x00; cfg_out == 0 and irq == 0 after reset.
- Write 0x10=0x3C and 0x17=0xC3, then read both back -> 0x3C and 0xC3. cfg_out byte 0 = 0x3C and byte 7 = 0xC3 one cycle after each write. Write 0x00=0xFF -> ID still reads 0xA5.
- Pulse event_in[2], write IRQ_EN=0x04 -> STATUS reads 0x04 and irq=1. Write STATUS=0x04 -> STATUS 0x00 and irq=0 one cycle later. W1C 0x04 in the same cycle as a new event_in[2] edge -> bit stays 1.
- Write CTRL=0x81 twice back-to-back -> ctrl_pulse=0x81 for exactly 2 cycles then 0x00; a read of 0x05 returns 0x00.
- With REG_BANK_ERR_CNT_EN: 300 reads of 0x80 -> ERR_CNT reads 0xFF; write 0x06=0x00 -> reads 0x00. Without the macro, 0x06 reads 0x00 after the same stimulus.
- stat_in=64'h0123456789ABCDEF, read 0x20 and 0x27 -> 0xEF and 0x01. Assert reset during a CTRL pulse -> ctrl_pulse drops to 0 without waiting for a clock edge.
